// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master.
//   state_e               : FSM state encoding (IDLE=0, BUS=1, RESP=2)
//   DefaultTimeoutCycles  : strobe cycles without ack before a transfer is abandoned
//   DefaultToW            : width of the timeout counter
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned DefaultTimeoutCycles = 255;
  localparam int unsigned DefaultToW           = 8;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator.
// Takes one read/write command at a time on a valid/ready command port, runs it as a Wishbone
// cycle toward the peripheral decoder and returns read data or a timeout error on a valid/ready
// response port.
//
// Ports:
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake; cmd_we/cmd_adr/cmd_dat/cmd_sel payload
//   rsp_valid/rsp_ready       : response handshake; rsp_dat (0 for writes/errors), rsp_err
//   wbm_cyc_o .. wbm_dat_o    : Wishbone master outputs
//   wbm_dat_i, wbm_ack_i      : Wishbone slave return
//   busy                      : high whenever the FSM is not idle
//
// Every output is a register or a decode of registered state, so there is no combinational
// path from any input to any output.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned TO_W           = DefaultToW
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,

  output logic        busy
);

  // Count value seen during the last permitted strobe cycle.
  localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] MaxCnt  = {TO_W{1'b1}};

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;

  logic        timeout_hit;

  assign timeout_hit = (cnt_q == LastCnt);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          we_d      = cmd_we;
          sel_d     = cmd_sel;
          adr_d     = cmd_adr;
          dat_d     = cmd_dat;
          cnt_d     = '0;
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
          state_d   = StBus;
        end
      end

      StBus: begin
        // Saturating count of strobe cycles that ended without an ack.
        if (!wbm_ack_i && (cnt_q != MaxCnt)) begin
          cnt_d = cnt_q + TO_W'(1);
        end
        // Ack takes priority over a timeout landing in the same cycle.
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (timeout_hit) begin
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end
        // we/sel/dat must read as zero once the bus cycle is over.
        if (wbm_ack_i || timeout_hit) begin
          we_d  = 1'b0;
          sel_d = 4'h0;
          dat_d = 32'h0;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      cnt_q     <= '0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

  assign wbm_cyc_o = (state_q == StBus);
  assign wbm_stb_o = (state_q == StBus);
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: a driver issues commands and pushes the expected
// bus transfer and response, a slave model answers on Wishbone and checks the bus side, and a
// monitor pops and compares every response the DUT presents.
module tb_wb_cmd_master;

  localparam int unsigned T = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        busy;

  wb_cmd_master #(
    .TIMEOUT_CYCLES(T),
    .TO_W          (8)
  ) u_dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .busy     (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // delay: strobe-cycle number (counted from 1) on which the slave acks; 0 = never.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          delay;
    int          stb_exp;
    bit          abort;
  } plan_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  plan_t plan_q[$];
  rsp_t  exp_q[$];

  int tests = 0;
  int fails = 0;
  int rsp_done = 0;
  int bp_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model and bus-side checks.
  initial begin : slave
    plan_t cur;
    bit    in_xfer = 0;
    bit    seen_end = 0;
    int    k = 0;
    int    nstb = 0;
    forever begin
      @(negedge wb_clk_i);
      if (!in_xfer && wbm_stb_o) begin
        if (plan_q.size() == 0) begin
          check("unexpected_stb", 32'(wbm_stb_o), 32'h0);
        end else begin
          cur      = plan_q.pop_front();
          in_xfer  = 1;
          seen_end = 0;
          k        = 0;
          nstb     = 0;
        end
      end
      if (!wbm_stb_o) begin
        check("idle_cyc", 32'(wbm_cyc_o), 32'h0);
        check("idle_we", 32'(wbm_we_o), 32'h0);
        check("idle_sel", 32'(wbm_sel_o), 32'h0);
        check("idle_dat", wbm_dat_o, 32'h0);
      end
      if (in_xfer) begin
        k++;
        if (wbm_stb_o && !seen_end) begin
          nstb++;
          check("bus_cyc", 32'(wbm_cyc_o), 32'h1);
          check("bus_busy", 32'(busy), 32'h1);
          check("bus_we", 32'(wbm_we_o), 32'(cur.we));
          check("bus_adr", wbm_adr_o, cur.adr);
          check("bus_dat", wbm_dat_o, cur.dat);
          check("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
        end else if (!seen_end) begin
          seen_end = 1;
          check("stb_cycles", 32'(nstb), 32'(cur.stb_exp));
          if (!cur.abort) check("rsp_valid_latency", 32'(rsp_valid), 32'h1);
        end
        wbm_ack_i = (k == cur.delay);
        wbm_dat_i = wbm_ack_i ? cur.rdata : $urandom();
        if (seen_end && k >= cur.delay) in_xfer = 0;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom();
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin : monitor
    rsp_t        e;
    bit          holding = 0;
    bit          acked = 0;
    logic [31:0] h_dat = 32'h0;
    logic        h_err = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (rsp_valid) begin
        if (acked) check("rsp_valid_after_handshake", 32'(rsp_valid), 32'h0);
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'h0);
        if (!holding) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_dat", rsp_dat, e.dat);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
          end
          h_dat   = rsp_dat;
          h_err   = rsp_err;
          holding = 1;
        end else begin
          check("rsp_dat_stable", rsp_dat, h_dat);
          check("rsp_err_stable", 32'(rsp_err), 32'(h_err));
        end
        if (bp_left > 0) begin
          bp_left--;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
        if (rsp_ready) begin
          acked   = 1;
          holding = 0;
          rsp_done++;
        end else begin
          acked = 0;
        end
      end else begin
        rsp_ready = 1'b0;
        acked     = 0;
        holding   = 0;
      end
    end
  end

  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                        input int bp, input bit probe, input bit abort);
    plan_t p;
    rsp_t  r;
    bit    accepted = 0;
    int    target;
    p.we = we; p.adr = adr; p.dat = dat; p.sel = sel;
    p.rdata = rdata; p.delay = delay; p.abort = abort;
    // Reference: ack within the first T strobe cycles wins, otherwise timeout after T.
    if (delay >= 1 && delay <= int'(T)) begin
      p.stb_exp = delay;
      r.err     = 1'b0;
      r.dat     = we ? 32'h0 : rdata;
    end else begin
      p.stb_exp = T;
      r.err     = 1'b1;
      r.dat     = 32'h0;
    end
    if (abort) p.stb_exp = 3;
    target    = rsp_done + 1;
    bp_left   = bp;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (cmd_ready) begin
        plan_q.push_back(p);
        if (!abort) exp_q.push_back(r);
        accepted = 1;
      end
      @(negedge wb_clk_i);
    end
    cmd_valid = 1'b0;
    cmd_adr   = $urandom();
    if (!accepted) begin
      check("cmd_accept", 32'h0, 32'h1);
      return;
    end
    check("stb_after_accept", 32'(wbm_stb_o), 32'h1);
    if (abort) begin
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      check("rst_cyc", 32'(wbm_cyc_o), 32'h0);
      check("rst_stb", 32'(wbm_stb_o), 32'h0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      repeat (10) @(negedge wb_clk_i);
      return;
    end
    if (probe) begin
      for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge wb_clk_i);
      cmd_valid = 1'b1;
      repeat (5) begin
        check("bp_no_accept", 32'(cmd_ready), 32'h0);
        @(negedge wb_clk_i);
      end
      cmd_valid = 1'b0;
    end
    for (int i = 0; i < 200 && rsp_done < target; i++) @(negedge wb_clk_i);
    check("rsp_handshake", 32'(rsp_done >= target), 32'h1);
    repeat ($urandom_range(1, 3)) @(negedge wb_clk_i);
  endtask

  initial begin : driver
    repeat (3) @(negedge wb_clk_i);
    check("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_dat", rsp_dat, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_cyc", 32'(wbm_cyc_o), 32'h0);
    check("reset_stb", 32'(wbm_stb_o), 32'h0);
    check("reset_adr", wbm_adr_o, 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    do_txn(1'b1, 32'h3000_1004, 32'hDEAD_BEEF, 4'hF, 2, 32'h5555_AAAA, 0, 0, 0);
    do_txn(1'b0, 32'h3000_4000, 32'h0, 4'hF, 1, 32'h1234_5678, 0, 0, 0);
    do_txn(1'b0, 32'h3000_2008, 32'h0, 4'h3, T + 2, 32'h0BAD_0BAD, 0, 0, 0);
    do_txn(1'b0, 32'h3000_3010, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 10, 1, 0);
    do_txn(1'b1, 32'h3000_5000, 32'h1111_2222, 4'hC, 0, 32'h0, 0, 0, 1);
    do_txn(1'b0, 32'h3000_1ffc, 32'h0, 4'hF, T, 32'hA5A5_A5A5, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)),
             32'h3000_1000 + ($urandom_range(0, 20479) & 32'hFFFF_FFFC),
             $urandom(), 4'($urandom_range(1, 15)), $urandom_range(0, T + 2),
             $urandom(), $urandom_range(0, 3), 0, 0);
    end

    repeat (20) @(negedge wb_clk_i);
    check("plan_q_drained", 32'(plan_q.size()), 32'h0);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
